// File: rtl/rf_port_scheduler.sv
// rtl/rf_port_scheduler.sv - two-client arbitration front-end for a 2R/1W register file (optional RF_READ_MERGE_EN)
module rf_port_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  a_valid,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ready,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_valid,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ready,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [DATA_WIDTH-1:0] rf_din,
    output logic [ADDR_WIDTH-1:0] rf_wad1,
    output logic [ADDR_WIDTH-1:0] rf_rad1,
    output logic [ADDR_WIDTH-1:0] rf_rad2,
    output logic                  rf_wen1,
    output logic                  rf_ren1,
    output logic                  rf_ren2,
    input  logic [DATA_WIDTH-1:0] rf_dout1,
    input  logic [DATA_WIDTH-1:0] rf_dout2,
    input  logic                  rf_collision,
    output logic                  err,
    output logic [CNT_WIDTH-1:0]  stall_cnt
);

    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    logic                 rr_ptr_q, rr_ptr_d;
    logic                 a_rd_q, b_rd_q, b_mrg_q;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic same_addr, rr_conflict, conflict;
    logic a_grant, b_grant, merge_hit, stall;

    always_comb begin
        same_addr = (a_addr == b_addr);
`ifdef RF_READ_MERGE_EN
        rr_conflict = 1'b0;
`else
        rr_conflict = !a_we && !b_we && same_addr;
`endif
        conflict = a_valid && b_valid &&
                   ((a_we && b_we) || ((a_we != b_we) && same_addr) || rr_conflict);
        a_grant = resetn && a_valid && (!conflict || rr_ptr_q == PTR_A);
        b_grant = resetn && b_valid && (!conflict || rr_ptr_q == PTR_B);
`ifdef RF_READ_MERGE_EN
        // Same-address reads share read port 1; B's data is steered from dout1.
        merge_hit = a_grant && b_grant && !a_we && !b_we && same_addr;
`else
        merge_hit = 1'b0;
`endif
        stall = (a_valid && !a_grant) || (b_valid && !b_grant);
    end

    always_comb begin
        rf_wen1 = 1'b0;
        rf_wad1 = '0;
        rf_din  = '0;
        if (a_grant && a_we) begin
            rf_wen1 = 1'b1;
            rf_wad1 = a_addr;
            rf_din  = a_wdata;
        end else if (b_grant && b_we) begin
            rf_wen1 = 1'b1;
            rf_wad1 = b_addr;
            rf_din  = b_wdata;
        end
        rf_ren1 = a_grant && !a_we;
        rf_rad1 = rf_ren1 ? a_addr : '0;
        rf_ren2 = b_grant && !b_we && !merge_hit;
        rf_rad2 = rf_ren2 ? b_addr : '0;
    end

    always_comb begin
        rr_ptr_d    = conflict ? ~rr_ptr_q : rr_ptr_q;
        err_d       = err_q || rf_collision;
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != {CNT_WIDTH{1'b1}})
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rr_ptr_q    <= PTR_A;
            a_rd_q      <= 1'b0;
            b_rd_q      <= 1'b0;
            b_mrg_q     <= 1'b0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            a_rd_q      <= a_grant && !a_we;
            b_rd_q      <= b_grant && !b_we;
            b_mrg_q     <= merge_hit;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign a_ready   = a_grant;
    assign b_ready   = b_grant;
    assign a_rvalid  = a_rd_q;
    assign b_rvalid  = b_rd_q;
    assign a_rdata   = a_rd_q ? rf_dout1 : '0;
    assign b_rdata   = b_rd_q ? (b_mrg_q ? rf_dout1 : rf_dout2) : '0;
    assign err       = err_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_rf_port_scheduler.sv
// tb/tb_rf_port_scheduler.sv - directed vector bench for rf_port_scheduler with a behavioural register file
module tb_rf_port_scheduler;

`ifdef RF_READ_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_valid, a_we, b_valid, b_we;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ready, a_rvalid, b_ready, b_rvalid;
    logic [31:0] a_rdata, b_rdata;
    logic [31:0] rf_din, rf_dout1, rf_dout2;
    logic [4:0]  rf_wad1, rf_rad1, rf_rad2;
    logic        rf_wen1, rf_ren1, rf_ren2, rf_collision;
    logic        err;
    logic [15:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_port_scheduler dut (
        .clk(clk), .resetn(resetn),
        .a_valid(a_valid), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ready(a_ready), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ready(b_ready), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .rf_din(rf_din), .rf_wad1(rf_wad1), .rf_rad1(rf_rad1), .rf_rad2(rf_rad2),
        .rf_wen1(rf_wen1), .rf_ren1(rf_ren1), .rf_ren2(rf_ren2),
        .rf_dout1(rf_dout1), .rf_dout2(rf_dout2), .rf_collision(rf_collision),
        .err(err), .stall_cnt(stall_cnt)
    );

    // Register file model: synchronous read, data forced to 0 on a collision.
    logic [31:0] mem [32];
    logic        inject = 1'b0;
    logic        coll_now;
    logic        coll_seen = 1'b0;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = '0;
        rf_dout1 = '0;
        rf_dout2 = '0;
        rf_collision = 1'b0;
    end

    assign coll_now = inject ||
                      (rf_wen1 && rf_ren1 && rf_wad1 == rf_rad1) ||
                      (rf_wen1 && rf_ren2 && rf_wad1 == rf_rad2) ||
                      (rf_ren1 && rf_ren2 && rf_rad1 == rf_rad2);

    always @(posedge clk) begin
        if (rf_wen1) mem[rf_wad1] <= rf_din;
        if (rf_ren1) rf_dout1 <= coll_now ? 32'h0 : mem[rf_rad1];
        if (rf_ren2) rf_dout2 <= coll_now ? 32'h0 : mem[rf_rad2];
        rf_collision <= coll_now;
        if (rf_collision) coll_seen <= 1'b1;
    end

    typedef struct {
        logic        av, awe;
        logic [4:0]  aad;
        logic [31:0] awd;
        logic        bv, bwe;
        logic [4:0]  bad;
        logic [31:0] bwd;
        logic        ear, ebr, ewen, eren1, eren2;
        logic        earv;
        logic [31:0] eard;
        logic        ebrv;
        logic [31:0] ebrd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle();
        a_valid = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_valid = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    endtask

    initial begin
        vecs[0]  = '{1,1,5'd1,32'h11,       1,1,5'd2,32'h22, 1,0,1,0,0, 0,32'h0,        0,32'h0};
        vecs[1]  = '{0,0,5'd0,32'h0,        1,1,5'd2,32'h22, 0,1,1,0,0, 0,32'h0,        0,32'h0};
        vecs[2]  = '{1,1,5'd3,32'hDEADBEEF, 0,0,5'd0,32'h0,  1,0,1,0,0, 0,32'h0,        0,32'h0};
        vecs[3]  = '{1,0,5'd3,32'h0,        0,0,5'd0,32'h0,  1,0,0,1,0, 1,32'hDEADBEEF, 0,32'h0};
        vecs[4]  = '{1,0,5'd1,32'h0,        1,0,5'd2,32'h0,  1,1,0,1,1, 1,32'h11,       1,32'h22};
        vecs[5]  = '{1,1,5'd4,32'h44,       0,0,5'd0,32'h0,  1,0,1,0,0, 0,32'h0,        0,32'h0};
        vecs[6]  = '{1,1,5'd7,32'h55,       1,0,5'd7,32'h0,  0,1,0,0,1, 0,32'h0,        1,32'h0};
        vecs[7]  = '{1,1,5'd7,32'h55,       0,0,5'd0,32'h0,  1,0,1,0,0, 0,32'h0,        0,32'h0};
        vecs[8]  = '{0,0,5'd0,32'h0,        1,0,5'd7,32'h0,  0,1,0,0,1, 0,32'h0,        1,32'h55};
        vecs[9]  = '{1,0,5'd4,32'h0,        1,0,5'd4,32'h0,  1,MERGE,0,1,0, 1,32'h44,   MERGE,(MERGE ? 32'h44 : 32'h0)};
        vecs[10] = '{0,0,5'd0,32'h0,        1,0,5'd4,32'h0,  0,1,0,0,1, 0,32'h0,        1,32'h44};

        // Reset state, with both clients requesting.
        resetn = 0;
        idle();
        a_valid = 1; a_we = 1; b_valid = 1; b_we = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset a_ready", a_ready, 0);
        chk("reset b_ready", b_ready, 0);
        chk("reset rf_wen1", rf_wen1, 0);
        chk("reset rf_ren1/2", {rf_ren1, rf_ren2}, 0);
        chk("reset a_rvalid", a_rvalid, 0);
        chk("reset err", err, 0);
        chk("reset stall_cnt", stall_cnt, 0);
        resetn = 1;
        idle();

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            a_valid = vecs[i].av; a_we = vecs[i].awe; a_addr = vecs[i].aad; a_wdata = vecs[i].awd;
            b_valid = vecs[i].bv; b_we = vecs[i].bwe; b_addr = vecs[i].bad; b_wdata = vecs[i].bwd;
            #1;
            chk($sformatf("v%0d a_ready", i), a_ready, vecs[i].ear);
            chk($sformatf("v%0d b_ready", i), b_ready, vecs[i].ebr);
            chk($sformatf("v%0d rf_wen1", i), rf_wen1, vecs[i].ewen);
            chk($sformatf("v%0d rf_ren1", i), rf_ren1, vecs[i].eren1);
            chk($sformatf("v%0d rf_ren2", i), rf_ren2, vecs[i].eren2);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d a_rvalid", i), a_rvalid, vecs[i].earv);
            chk($sformatf("v%0d a_rdata", i), a_rdata, vecs[i].eard);
            chk($sformatf("v%0d b_rvalid", i), b_rvalid, vecs[i].ebrv);
            chk($sformatf("v%0d b_rdata", i), b_rdata, vecs[i].ebrd);
        end
        @(negedge clk);
        idle();
        chk("stall_cnt after table", stall_cnt, MERGE ? 2 : 3);
        chk("no collision in table", {coll_seen, err}, 0);

        // Injected file collision: response still raised with data 0, err sticks.
        @(negedge clk);
        a_valid = 1; a_we = 0; a_addr = 5'd1; inject = 1;
        @(posedge clk);
        #1;
        inject = 0;
        idle();
        chk("coll a_rvalid", a_rvalid, 1);
        chk("coll a_rdata", a_rdata, 0);
        @(posedge clk);
        #1;
        chk("coll err set", err, 1);
        @(posedge clk);
        #1;
        chk("coll err sticky", err, 1);

        // Reset asserted on the edge that would register a granted read.
        @(negedge clk);
        a_valid = 1; a_we = 0; a_addr = 5'd3;
        #1;
        chk("midreset grant", a_ready, 1);
        resetn = 0;
        #1;
        chk("midreset ready low", a_ready, 0);
        @(posedge clk);
        #1;
        chk("midreset a_rvalid", a_rvalid, 0);
        chk("midreset err", err, 0);
        chk("midreset stall_cnt", stall_cnt, 0);
        @(negedge clk);
        resetn = 1;
        idle();
        @(posedge clk);
        #1;
        chk("post-reset a_rvalid", a_rvalid, 0);

        // rr_ptr back at A: write/write conflict goes to A.
        @(negedge clk);
        a_valid = 1; a_we = 1; a_addr = 5'd9; b_valid = 1; b_we = 1; b_addr = 5'd10;
        #1;
        chk("post-reset ww a_ready", a_ready, 1);
        chk("post-reset ww b_ready", b_ready, 0);
        @(negedge clk);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
